// File: rtl/fetch_if_id_stage.sv
// Instruction-fetch stage and IF/ID pipeline register.
// Keeps the fetch PC, issues one instruction-memory request at a time, and
// presents the returned instruction (with its PC and PC+4) to decode. A
// one-entry hold buffer absorbs a response that lands while decode is
// stalled; redirects restart fetch and discard any response still in flight.
module fetch_if_id_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_d,
    input  logic        flush_d,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc_plus4_d,
    output logic        valid_d
);

    // StIssue: request this cycle; StWait: awaiting the response;
    // StHold: response parked in the hold buffer; StDrop: response to discard.
    typedef enum logic [1:0] {
        StIssue,
        StWait,
        StHold,
        StDrop
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_f_q, pc_f_d;

    logic [31:0] hold_instr_q, hold_instr_d;
    logic [31:0] hold_pc_q, hold_pc_d;
    logic        hold_full_q, hold_full_d;

    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_pc4_q, ifid_pc4_d;
    logic        ifid_valid_q, ifid_valid_d;

    // An instruction ready to enter IF/ID this edge (from memory or the hold buffer).
    logic        load_new;
    logic [31:0] new_instr;
    logic [31:0] new_pc;

    // Redirect targets are always word aligned; the low two bits are dropped.
    logic [31:0] redirect_target;
    assign redirect_target = redirect_pc & 32'hFFFF_FFFC;

    assign imem_addr = pc_f_q;

    // Fetch FSM: next state, fetch PC, hold buffer and request strobe.
    always_comb begin
        state_d      = state_q;
        pc_f_d       = pc_f_q;
        hold_instr_d = hold_instr_q;
        hold_pc_d    = hold_pc_q;
        hold_full_d  = hold_full_q;
        load_new     = 1'b0;
        new_instr    = imem_rdata;
        new_pc       = pc_f_q;
        imem_req     = 1'b0;

        unique case (state_q)
            StIssue: begin
                // A redirect in the issue cycle suppresses the request to the stale PC.
                imem_req = !redirect_valid;
                if (redirect_valid) begin
                    pc_f_d = redirect_target;
                end else begin
                    state_d = StWait;
                end
            end

            StWait: begin
                if (imem_rvalid) begin
                    if (redirect_valid) begin
                        // Response belongs to the wrong path; drop it.
                        pc_f_d  = redirect_target;
                        state_d = StIssue;
                    end else if (stall_d) begin
                        hold_instr_d = imem_rdata;
                        hold_pc_d    = pc_f_q;
                        hold_full_d  = 1'b1;
                        state_d      = StHold;
                    end else begin
                        load_new  = 1'b1;
                        new_instr = imem_rdata;
                        new_pc    = pc_f_q;
                        pc_f_d    = pc_f_q + 32'd4;
                        state_d   = StIssue;
                    end
                end else if (redirect_valid) begin
                    // Request still outstanding: its response must be swallowed.
                    pc_f_d  = redirect_target;
                    state_d = StDrop;
                end
            end

            StHold: begin
                if (redirect_valid) begin
                    hold_full_d = 1'b0;
                    pc_f_d      = redirect_target;
                    state_d     = StIssue;
                end else if (!stall_d && hold_full_q) begin
                    load_new    = 1'b1;
                    new_instr   = hold_instr_q;
                    new_pc      = hold_pc_q;
                    pc_f_d      = hold_pc_q + 32'd4;
                    hold_full_d = 1'b0;
                    state_d     = StIssue;
                end
            end

            StDrop: begin
                if (redirect_valid) begin
                    pc_f_d = redirect_target;
                end
                if (imem_rvalid) begin
                    state_d = StIssue;
                end
            end

            default: begin
                state_d = StIssue;
            end
        endcase
    end

    // IF/ID next value: redirect/flush bubble > stall hold > new instruction > bubble.
    always_comb begin
        ifid_instr_d = ifid_instr_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_valid_d = ifid_valid_q;

        if (redirect_valid || flush_d) begin
            // PC fields are left alone; only the slot is killed.
            ifid_valid_d = 1'b0;
            ifid_instr_d = NOP_INSTR;
        end else if (stall_d) begin
            ifid_valid_d = ifid_valid_q;
        end else if (load_new) begin
            ifid_instr_d = new_instr;
            ifid_pc_d    = new_pc;
            ifid_pc4_d   = new_pc + 32'd4;
            ifid_valid_d = 1'b1;
        end else begin
            ifid_valid_d = 1'b0;
            ifid_instr_d = NOP_INSTR;
        end
    end

    // State, fetch PC, hold buffer and IF/ID registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIssue;
            pc_f_q       <= RESET_PC;
            hold_instr_q <= 32'h0;
            hold_pc_q    <= 32'h0;
            hold_full_q  <= 1'b0;
            ifid_instr_q <= NOP_INSTR;
            ifid_pc_q    <= 32'h0;
            ifid_pc4_q   <= 32'h0;
            ifid_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_f_q       <= pc_f_d;
            hold_instr_q <= hold_instr_d;
            hold_pc_q    <= hold_pc_d;
            hold_full_q  <= hold_full_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_valid_q <= ifid_valid_d;
        end
    end

    assign instr_d    = ifid_instr_q;
    assign pc_d       = ifid_pc_q;
    assign pc_plus4_d = ifid_pc4_q;
    assign valid_d    = ifid_valid_q;

endmodule

// File: tb/tb_fetch_if_id_stage.sv
// Bench for fetch_if_id_stage: directed scenarios followed by random
// stall/flush/redirect/reset traffic against a transaction-level model.
module tb_fetch_if_id_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_d = 1'b0;
    logic        flush_d = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pc_plus4_d;
    logic        valid_d;

    always #5 clk = ~clk;

    fetch_if_id_stage #(
        .RESET_PC (RESET_PC),
        .NOP_INSTR(NOP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall_d       (stall_d),
        .flush_d       (flush_d),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .instr_d       (instr_d),
        .pc_d          (pc_d),
        .pc_plus4_d    (pc_plus4_d),
        .valid_d       (valid_d)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory: one pending response, answered 'pend' cycles after the request.
    int          pend = 0;
    int          lat = 1;          // 0 selects a random latency of 1..3
    logic [31:0] pend_data = 32'h0;
    logic        force_en = 1'b0;
    logic [31:0] force_data = 32'h0;

    // Reference model: fetch address plus what happened to the last request.
    logic [31:0] m_pc;
    logic        m_inflight;       // a request is outstanding
    logic        m_discard;        // its response will be thrown away
    logic        m_held;           // a stalled response is parked
    logic [31:0] m_hinstr;
    logic [31:0] m_instr, m_pcd, m_pc4;
    logic        m_valid;

    logic        last_req;
    logic [31:0] last_addr;

    task automatic drive_mem();
        imem_rvalid = (pend == 1);
        imem_rdata  = (pend == 1) ? pend_data : $urandom();
    endtask

    task automatic model_reset();
        m_pc = RESET_PC; m_inflight = 0; m_discard = 0; m_held = 0; m_hinstr = 0;
        m_instr = NOP; m_pcd = 0; m_pc4 = 0; m_valid = 0;
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1; stall_d = 0; flush_d = 0; redirect_valid = 0;
        drive_mem();
        #1;
        check_eq("rst_valid_d", valid_d, 0);
        check_eq("rst_instr_d", instr_d, NOP);
        check_eq("rst_pc_d", pc_d, 0);
        check_eq("rst_pc_plus4_d", pc_plus4_d, 0);
        check_eq("rst_imem_addr", imem_addr, RESET_PC);
        check_eq("rst_imem_req", imem_req, 1);
        model_reset();
        @(posedge clk);
        if (pend > 0) pend--;
        for (int k = 1; k < n; k++) begin
            @(negedge clk);
            drive_mem();
            @(posedge clk);
            if (pend > 0) pend--;
        end
    endtask

    task automatic step(input logic s, input logic f, input logic r, input logic [31:0] rp);
        logic        exp_req, got_req, rv, avail;
        logic [31:0] rd, tgt, n_instr, n_pc;
        @(negedge clk);
        rst = 0; stall_d = s; flush_d = f; redirect_valid = r; redirect_pc = rp;
        drive_mem();
        #1;
        exp_req = !m_inflight && !m_held && !r;
        check_eq("imem_req", imem_req, exp_req);
        check_eq("imem_addr", imem_addr, m_pc);
        last_req = imem_req; last_addr = imem_addr;
        got_req = imem_req; rv = imem_rvalid; rd = imem_rdata;
        @(posedge clk);
        if (pend > 0) pend--;
        if (got_req) begin
            pend = (lat == 0) ? int'($urandom_range(1, 3)) : lat;
            pend_data = force_en ? force_data : $urandom();
            force_en = 0;
        end
        // Model: follow the fate of the request and any parked instruction.
        avail = 0; n_instr = 0; n_pc = 0; tgt = rp & 32'hFFFF_FFFC;
        if (!m_inflight && !m_held) begin
            if (r) m_pc = tgt;
            else begin m_inflight = 1; m_discard = 0; end
        end else if (m_inflight) begin
            if (rv) begin
                m_inflight = 0;
                if (r) m_pc = tgt;
                else if (!m_discard) begin
                    if (s) begin m_held = 1; m_hinstr = rd; end
                    else begin avail = 1; n_instr = rd; n_pc = m_pc; m_pc = m_pc + 4; end
                end
                m_discard = 0;
            end else if (r) begin
                m_pc = tgt; m_discard = 1;
            end
        end else begin
            if (r) begin m_held = 0; m_pc = tgt; end
            else if (!s) begin
                avail = 1; n_instr = m_hinstr; n_pc = m_pc; m_pc = m_pc + 4; m_held = 0;
            end
        end
        if (r || f) begin m_valid = 0; m_instr = NOP; end
        else if (s) begin end
        else if (avail) begin m_instr = n_instr; m_pcd = n_pc; m_pc4 = n_pc + 4; m_valid = 1; end
        else begin m_valid = 0; m_instr = NOP; end
        #1;
        check_eq("valid_d", valid_d, m_valid);
        check_eq("instr_d", instr_d, m_instr);
        check_eq("pc_d", pc_d, m_pcd);
        check_eq("pc_plus4_d", pc_plus4_d, m_pc4);
    endtask

    initial begin
        model_reset();
        do_reset(2);

        // Back-to-back fetch with single-cycle memory.
        lat = 1;
        for (int k = 0; k < 6; k++) begin
            step(0, 0, 0, 0);
            if (k == 4) check_eq("seq_addr_8", last_addr, 32'h8);
        end
        check_eq("seq_pc_d", pc_d, 32'h8);
        check_eq("seq_pc_plus4_d", pc_plus4_d, 32'hC);
        check_eq("seq_valid_d", valid_d, 1);

        // Response lands during a 3-cycle stall.
        force_en = 1; force_data = 32'h0050_0093;
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        check_eq("stall_no_req", last_req, 0);
        check_eq("stall_prior_pc_d", pc_d, 32'h8);
        step(0, 0, 0, 0);
        check_eq("hold_instr_d", instr_d, 32'h0050_0093);
        check_eq("hold_valid_d", valid_d, 1);
        check_eq("hold_pc_d", pc_d, 32'hC);
        check_eq("hold_next_addr", imem_addr, 32'h10);

        // Redirect while waiting; late response must be dropped.
        lat = 3;
        step(0, 0, 0, 0);
        step(0, 0, 1, 32'h0000_0103);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        check_eq("drop_valid_d", valid_d, 0);
        check_eq("drop_instr_d", instr_d, NOP);
        check_eq("drop_next_addr", imem_addr, 32'h100);

        // Redirect in the issue cycle.
        lat = 1;
        step(0, 0, 1, 32'h0000_0200);
        check_eq("redir_issue_req", last_req, 0);
        step(0, 0, 0, 0);
        check_eq("redir_issue_req_next", last_req, 1);
        check_eq("redir_issue_addr_next", last_addr, 32'h200);

        // Flush with stall on a valid slot.
        step(0, 0, 0, 0);
        check_eq("pre_flush_valid", valid_d, 1);
        step(1, 1, 0, 0);
        check_eq("flush_valid_d", valid_d, 0);
        check_eq("flush_instr_d", instr_d, NOP);
        check_eq("flush_pc_d", pc_d, 32'h200);
        check_eq("flush_pc_f", imem_addr, 32'h204);

        // Wrap of PC arithmetic, then reset during WAIT with a late response.
        step(0, 0, 1, 32'hFFFF_FFFC);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        check_eq("wrap_pc_d", pc_d, 32'hFFFF_FFFC);
        check_eq("wrap_pc_plus4_d", pc_plus4_d, 32'h0);
        check_eq("wrap_next_addr", imem_addr, 32'h0);
        lat = 3;
        step(0, 0, 0, 0);
        do_reset(2);
        step(0, 0, 0, 0);
        check_eq("stale_req", last_req, 1);
        check_eq("stale_addr", last_addr, RESET_PC);
        check_eq("stale_valid_d", valid_d, 0);

        // Random traffic.
        lat = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset(int'($urandom_range(1, 3)));
            end else begin
                step($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 10,
                     $urandom_range(0, 99) < 8, $urandom());
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
